iso14443a_tag_rx_decoder: RTL and testbench

Decodes the ISO14443-A tag-to-reader Manchester bitstream carried by the 848 kHz subcarrier modulation-detect bit (`curbit`) into bytes with odd-parity checking and frame delimiting. It sits directly downstream of the subcarrier modulation detector in the HF reader path, consuming one detector sample per 16 carrier cycles. It replaces raw per-sample forwarding to the ARM with byte-level results.

---
 rtl/iso14443a_tag_rx_decoder.sv | 270 +++++++++++++++++++++++++++
 tb/tb_iso14443a_tag_rx_decoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iso14443a_tag_rx_decoder.sv
// iso14443a_tag_rx_decoder
// Turns the 848 kHz subcarrier modulation-detect samples (one per strobe)
// into Manchester bits, then into 9-bit groups (8 data bits plus odd parity)
// with SOF qualification, EOF detection, collision tracking and a per-frame
// byte limit. All state advances on the falling carrier edge so that it
// lines up with the upstream modulation detector.
module iso14443a_tag_rx_decoder #(
   parameter int HALF_SAMPLES = 4,
   parameter int MAJ          = 2,
   parameter int MAX_BYTES    = 64
) (
   input  logic       ck_1356meg,
   input  logic       rst,
   input  logic       enable,
   input  logic       sample_stb,
   input  logic       curbit,
   output logic [7:0] byte_data,
   output logic       byte_parity_err,
   output logic       byte_valid,
   output logic       frame_active,
   output logic       frame_done,
   output logic [7:0] frame_bytes,
   output logic [3:0] frame_tail_bits,
   output logic       frame_collision,
   output logic       frame_overflow
);

   localparam int SW = $clog2(2 * HALF_SAMPLES);
   localparam int HW = $clog2(HALF_SAMPLES + 1);
   localparam logic [SW-1:0] HALF_S     = SW'(HALF_SAMPLES);
   localparam logic [SW-1:0] LAST_S     = SW'(2 * HALF_SAMPLES - 1);
   localparam logic [HW-1:0] MAJ_H      = HW'(MAJ);
   localparam logic [7:0]    MAX_C      = 8'(MAX_BYTES);
   localparam logic [3:0]    QUIET_LAST = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SOF   = 2'd1,
      ST_DATA  = 2'd2,
      ST_QUIET = 2'd3
   } state_t;

   // A 9-bit group is bad when it carries an even number of ones.
   function automatic logic parity_bad(input logic [8:0] grp);
      return ~(^grp);
   endfunction

   state_t        state_r, state_s;
   logic [SW-1:0] samp_cnt_r, samp_cnt_s;
   logic [HW-1:0] h1_r, h1_s, h2_r, h2_s;
   logic [7:0]    asm_r, asm_s;
   logic [3:0]    bit_cnt_r, bit_cnt_s;
   logic [7:0]    byte_cnt_r, byte_cnt_s;
   logic          coll_r, coll_s;
   logic [3:0]    quiet_cnt_r, quiet_cnt_s;

   logic [7:0]    byte_data_r, byte_data_s;
   logic          byte_parity_err_r, byte_parity_err_s;
   logic          byte_valid_r, byte_valid_s;
   logic          frame_active_r, frame_active_s;
   logic          frame_done_r, frame_done_s;
   logic [7:0]    frame_bytes_r, frame_bytes_s;
   logic [3:0]    frame_tail_bits_r, frame_tail_bits_s;
   logic          frame_collision_r, frame_collision_s;
   logic          frame_overflow_r, frame_overflow_s;

   // Half-bit accumulation including the sample currently on the bus.
   logic          first_half_s, last_s;
   logic [HW-1:0] h1_acc_s, h2_acc_s;
   logic          m1_s, m2_s, bit_val_s, coll_bit_s, eof_s;

   assign first_half_s = (samp_cnt_r < HALF_S);
   assign last_s       = (samp_cnt_r == LAST_S);
   assign h1_acc_s     = h1_r + HW'(first_half_s & curbit);
   assign h2_acc_s     = h2_r + HW'(~first_half_s & curbit);
   assign m1_s         = (h1_acc_s >= MAJ_H);
   assign m2_s         = (h2_acc_s >= MAJ_H);
   // A collision (both halves modulated) decodes as 1, so the bit value is m1.
   assign bit_val_s    = m1_s;
   assign coll_bit_s   = m1_s & m2_s;
   assign eof_s        = ~m1_s & ~m2_s;

   // Next-state and next-output computation for the decoder FSM.
   always_comb begin
      state_s           = state_r;
      samp_cnt_s        = samp_cnt_r;
      h1_s              = h1_r;
      h2_s              = h2_r;
      asm_s             = asm_r;
      bit_cnt_s         = bit_cnt_r;
      byte_cnt_s        = byte_cnt_r;
      coll_s            = coll_r;
      quiet_cnt_s       = quiet_cnt_r;
      byte_data_s       = byte_data_r;
      byte_parity_err_s = byte_parity_err_r;
      byte_valid_s      = 1'b0;
      frame_active_s    = frame_active_r;
      frame_done_s      = 1'b0;
      frame_bytes_s     = frame_bytes_r;
      frame_tail_bits_s = frame_tail_bits_r;
      frame_collision_s = frame_collision_r;
      frame_overflow_s  = frame_overflow_r;

      case (state_r)
         ST_IDLE: begin
            // The first modulated sample is taken as sample 0 of the SOF bit.
            if (sample_stb && curbit) begin
               samp_cnt_s = SW'(1);
               h1_s       = HW'(1);
               h2_s       = '0;
               state_s    = ST_SOF;
            end else begin
               state_s    = ST_IDLE;
            end
         end

         ST_SOF: begin
            if (sample_stb) begin
               if (last_s) begin
                  samp_cnt_s = '0;
                  h1_s       = '0;
                  h2_s       = '0;
                  if (m1_s) begin
                     state_s        = ST_DATA;
                     frame_active_s = 1'b1;
                     asm_s          = 8'd0;
                     bit_cnt_s      = 4'd0;
                     byte_cnt_s     = 8'd0;
                     coll_s         = 1'b0;
                  end else begin
                     // Too little modulation for a real SOF: treat as a glitch.
                     state_s        = ST_IDLE;
                  end
               end else begin
                  samp_cnt_s = samp_cnt_r + SW'(1);
                  h1_s       = h1_acc_s;
                  h2_s       = h2_acc_s;
               end
            end else begin
               state_s = ST_SOF;
            end
         end

         ST_DATA: begin
            if (sample_stb) begin
               if (last_s) begin
                  samp_cnt_s = '0;
                  h1_s       = '0;
                  h2_s       = '0;
                  if (eof_s) begin
                     // Residual bits are already right-aligned in the assembler.
                     frame_done_s      = 1'b1;
                     frame_active_s    = 1'b0;
                     frame_bytes_s     = byte_cnt_r;
                     frame_tail_bits_s = bit_cnt_r;
                     byte_data_s       = asm_r;
                     frame_collision_s = coll_r;
                     frame_overflow_s  = 1'b0;
                     state_s           = ST_IDLE;
                  end else if (bit_cnt_r == 4'd8) begin
                     if (byte_cnt_r == MAX_C) begin
                        // One byte too many: abort and ignore the rest of the burst.
                        frame_done_s      = 1'b1;
                        frame_active_s    = 1'b0;
                        frame_bytes_s     = MAX_C;
                        frame_tail_bits_s = 4'd0;
                        frame_collision_s = coll_r | coll_bit_s;
                        frame_overflow_s  = 1'b1;
                        quiet_cnt_s       = 4'd0;
                        state_s           = ST_QUIET;
                     end else begin
                        byte_valid_s      = 1'b1;
                        byte_data_s       = asm_r;
                        byte_parity_err_s = parity_bad({bit_val_s, asm_r});
                        byte_cnt_s        = byte_cnt_r + 8'd1;
                        asm_s             = 8'd0;
                        bit_cnt_s         = 4'd0;
                        coll_s            = coll_r | coll_bit_s;
                     end
                  end else begin
                     asm_s[bit_cnt_r[2:0]] = bit_val_s;
                     bit_cnt_s             = bit_cnt_r + 4'd1;
                     coll_s                = coll_r | coll_bit_s;
                  end
               end else begin
                  samp_cnt_s = samp_cnt_r + SW'(1);
                  h1_s       = h1_acc_s;
                  h2_s       = h2_acc_s;
               end
            end else begin
               state_s = ST_DATA;
            end
         end

         ST_QUIET: begin
            // Need one full bit time of silence before listening again.
            if (sample_stb) begin
               if (curbit) begin
                  quiet_cnt_s = 4'd0;
               end else if (quiet_cnt_r == QUIET_LAST) begin
                  quiet_cnt_s = 4'd0;
                  state_s     = ST_IDLE;
               end else begin
                  quiet_cnt_s = quiet_cnt_r + 4'd1;
               end
            end else begin
               state_s = ST_QUIET;
            end
         end

         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset or disable clears everything silently.
   always_ff @(negedge ck_1356meg) begin
      if (rst || !enable) begin
         state_r           <= ST_IDLE;
         samp_cnt_r        <= '0;
         h1_r              <= '0;
         h2_r              <= '0;
         asm_r             <= 8'd0;
         bit_cnt_r         <= 4'd0;
         byte_cnt_r        <= 8'd0;
         coll_r            <= 1'b0;
         quiet_cnt_r       <= 4'd0;
         byte_data_r       <= 8'd0;
         byte_parity_err_r <= 1'b0;
         byte_valid_r      <= 1'b0;
         frame_active_r    <= 1'b0;
         frame_done_r      <= 1'b0;
         frame_bytes_r     <= 8'd0;
         frame_tail_bits_r <= 4'd0;
         frame_collision_r <= 1'b0;
         frame_overflow_r  <= 1'b0;
      end else begin
         state_r           <= state_s;
         samp_cnt_r        <= samp_cnt_s;
         h1_r              <= h1_s;
         h2_r              <= h2_s;
         asm_r             <= asm_s;
         bit_cnt_r         <= bit_cnt_s;
         byte_cnt_r        <= byte_cnt_s;
         coll_r            <= coll_s;
         quiet_cnt_r       <= quiet_cnt_s;
         byte_data_r       <= byte_data_s;
         byte_parity_err_r <= byte_parity_err_s;
         byte_valid_r      <= byte_valid_s;
         frame_active_r    <= frame_active_s;
         frame_done_r      <= frame_done_s;
         frame_bytes_r     <= frame_bytes_s;
         frame_tail_bits_r <= frame_tail_bits_s;
         frame_collision_r <= frame_collision_s;
         frame_overflow_r  <= frame_overflow_s;
      end
   end

   assign byte_data       = byte_data_r;
   assign byte_parity_err = byte_parity_err_r;
   assign byte_valid      = byte_valid_r;
   assign frame_active    = frame_active_r;
   assign frame_done      = frame_done_r;
   assign frame_bytes     = frame_bytes_r;
   assign frame_tail_bits = frame_tail_bits_r;
   assign frame_collision = frame_collision_r;
   assign frame_overflow  = frame_overflow_r;

endmodule

// File: tb/tb_iso14443a_tag_rx_decoder.sv
// Testbench for iso14443a_tag_rx_decoder: builds frames as lists of logical
// bits, renders each bit as randomized detector samples with jittered strobe
// spacing, and compares the decoder's byte/frame events with a group-of-nine
// reference model of the frame.
module tb_iso14443a_tag_rx_decoder;

   localparam int MAJ  = 2;
   localparam int MAXB = 2;

   logic       ck_1356meg = 1'b0;
   logic       rst;
   logic       enable;
   logic       sample_stb;
   logic       curbit;
   logic [7:0] byte_data;
   logic       byte_parity_err;
   logic       byte_valid;
   logic       frame_active;
   logic       frame_done;
   logic [7:0] frame_bytes;
   logic [3:0] frame_tail_bits;
   logic       frame_collision;
   logic       frame_overflow;

   int checks = 0;
   int errors = 0;

   typedef struct { logic [7:0] d; logic pe; } bev_t;
   typedef struct { logic [7:0] nb; logic [3:0] tail; logic [7:0] d; logic coll; logic ovf; } fev_t;

   bev_t bq_mon[$];
   fev_t fq_mon[$];
   int   both_viol  = 0;
   int   act_viol   = 0;
   int   fa_cycles  = 0;

   // Bit kinds: 0/1 data, 2 collision, 3 EOF (silent), 4 SOF, 5 all-ones collision.
   int   bits[$];

   always #5 ck_1356meg = ~ck_1356meg;

   iso14443a_tag_rx_decoder #(
      .HALF_SAMPLES (4),
      .MAJ          (MAJ),
      .MAX_BYTES    (MAXB)
   ) u_dut (
      .ck_1356meg      (ck_1356meg),
      .rst             (rst),
      .enable          (enable),
      .sample_stb      (sample_stb),
      .curbit          (curbit),
      .byte_data       (byte_data),
      .byte_parity_err (byte_parity_err),
      .byte_valid      (byte_valid),
      .frame_active    (frame_active),
      .frame_done      (frame_done),
      .frame_bytes     (frame_bytes),
      .frame_tail_bits (frame_tail_bits),
      .frame_collision (frame_collision),
      .frame_overflow  (frame_overflow)
   );

   // Event capture on the rising edge, away from the DUT's falling edge.
   always @(posedge ck_1356meg) begin
      if (byte_valid) bq_mon.push_back('{byte_data, byte_parity_err});
      if (frame_done) fq_mon.push_back('{frame_bytes, frame_tail_bits, byte_data, frame_collision, frame_overflow});
      if (byte_valid && frame_done) both_viol <= both_viol + 1;
      if (frame_done && frame_active) act_viol <= act_viol + 1;
      if (frame_active) fa_cycles <= fa_cycles + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] half_pat(input bit modv);
      logic [3:0] p;
      do p = 4'($urandom); while ((($countones(p) >= MAJ) ? 1'b1 : 1'b0) != modv);
      return p;
   endfunction

   task automatic send_sample(input logic b);
      @(posedge ck_1356meg);
      sample_stb = 1'b1;
      curbit     = b;
      @(posedge ck_1356meg);
      sample_stb = 1'b0;
      curbit     = 1'($urandom);
      repeat ($urandom_range(0, 6)) @(posedge ck_1356meg);
   endtask

   task automatic send_bit(input int kind);
      logic [3:0] a, b;
      case (kind)
         0:       begin a = half_pat(1'b0);           b = half_pat(1'b1); end
         1:       begin a = half_pat(1'b1);           b = half_pat(1'b0); end
         2:       begin a = half_pat(1'b1);           b = half_pat(1'b1); end
         4:       begin a = half_pat(1'b1) | 4'b0001; b = half_pat(1'b0); end
         5:       begin a = 4'hF;                     b = 4'hF;           end
         default: begin a = half_pat(1'b0);           b = half_pat(1'b0); end
      endcase
      for (int i = 0; i < 4; i++) send_sample(a[i]);
      for (int i = 0; i < 4; i++) send_sample(b[i]);
   endtask

   task automatic push_byte(input logic [7:0] d, input logic p);
      for (int i = 0; i < 8; i++) bits.push_back(int'(d[i]));
      bits.push_back(int'(p));
   endtask

   // Expected results come from cutting the bit list into groups of nine.
   task automatic run_frame(input string tag);
      int bs, fs, n, i, tail;
      logic [7:0] ed, rd;
      logic pe, coll, ovf;
      bev_t eb[$];
      fev_t f;
      bs = bq_mon.size();
      fs = fq_mon.size();
      n = bits.size();
      i = 0; coll = 1'b0; ovf = 1'b0;
      while ((i + 9 <= n) && !ovf) begin
         for (int k = 0; k < 9; k++) if (bits[i+k] == 2 || bits[i+k] == 5) coll = 1'b1;
         if (eb.size() == MAXB) begin
            ovf = 1'b1;
         end else begin
            for (int k = 0; k < 8; k++) ed[k] = (bits[i+k] != 0);
            pe = ((($countones(ed) + ((bits[i+8] != 0) ? 1 : 0)) % 2) == 0);
            eb.push_back('{ed, pe});
            i += 9;
         end
      end
      rd = 8'd0;
      tail = ovf ? 0 : n - i;
      if (!ovf) begin
         for (int k = 0; k < tail; k++) begin
            rd[k] = (bits[i+k] != 0);
            if (bits[i+k] == 2 || bits[i+k] == 5) coll = 1'b1;
         end
      end

      send_bit(4);
      chk({tag, ".active_after_sof"}, 32'(frame_active), 32'd1);
      foreach (bits[k]) send_bit(bits[k]);
      send_bit(3);
      repeat (12) send_sample(1'b0);
      repeat (3) @(posedge ck_1356meg);

      chk({tag, ".nbytes"}, 32'(bq_mon.size() - bs), 32'(eb.size()));
      for (int k = 0; k < eb.size() && (bs + k) < bq_mon.size(); k++) begin
         chk($sformatf("%s.byte%0d", tag, k), 32'(bq_mon[bs+k].d), 32'(eb[k].d));
         chk($sformatf("%s.perr%0d", tag, k), 32'(bq_mon[bs+k].pe), 32'(eb[k].pe));
      end
      chk({tag, ".nframes"}, 32'(fq_mon.size() - fs), 32'd1);
      if (fq_mon.size() > fs) begin
         f = fq_mon[fs];
         chk({tag, ".frame_bytes"}, 32'(f.nb), ovf ? 32'(MAXB) : 32'(eb.size()));
         chk({tag, ".tail"}, 32'(f.tail), 32'(tail));
         chk({tag, ".overflow"}, 32'(f.ovf), 32'(ovf));
         chk({tag, ".collision"}, 32'(f.coll), 32'(coll));
         if (!ovf) chk({tag, ".residual"}, 32'(f.d), 32'(rd));
      end
      chk({tag, ".active_idle"}, 32'(frame_active), 32'd0);
      bits.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".byte_data"}, 32'(byte_data), 32'd0);
      chk({tag, ".perr"}, 32'(byte_parity_err), 32'd0);
      chk({tag, ".valid"}, 32'(byte_valid), 32'd0);
      chk({tag, ".active"}, 32'(frame_active), 32'd0);
      chk({tag, ".done"}, 32'(frame_done), 32'd0);
      chk({tag, ".frame_bytes"}, 32'(frame_bytes), 32'd0);
      chk({tag, ".tail"}, 32'(frame_tail_bits), 32'd0);
      chk({tag, ".coll"}, 32'(frame_collision), 32'd0);
      chk({tag, ".ovf"}, 32'(frame_overflow), 32'd0);
   endtask

   // Start a frame, abort it mid-byte by reset or disable, and check silence.
   task automatic abort_case(input string tag, input bit use_rst);
      int bs, fs;
      bs = bq_mon.size();
      fs = fq_mon.size();
      send_bit(4);
      push_byte(8'h5A, 1'b1);
      bits.push_back(1); bits.push_back(0); bits.push_back(1); bits.push_back(1);
      foreach (bits[k]) send_bit(bits[k]);
      bits.delete();
      @(posedge ck_1356meg);
      if (use_rst) rst = 1'b1; else enable = 1'b0;
      repeat (2) @(posedge ck_1356meg);
      rst = 1'b0;
      enable = 1'b1;
      @(posedge ck_1356meg);
      chk_all_zero(tag);
      repeat (12) send_sample(1'b0);
      repeat (2) @(posedge ck_1356meg);
      chk({tag, ".nbytes"}, 32'(bq_mon.size() - bs), 32'd1);
      if (bq_mon.size() > bs) chk({tag, ".byte0"}, 32'(bq_mon[bs].d), 32'h5A);
      chk({tag, ".nframes"}, 32'(fq_mon.size() - fs), 32'd0);
   endtask

   initial begin
      int c0, bs, fs, nb, nt;
      logic [7:0] d;
      rst = 1'b1; enable = 1'b1; sample_stb = 1'b0; curbit = 1'b0;
      repeat (4) @(posedge ck_1356meg);
      chk_all_zero("reset");
      rst = 1'b0;
      repeat (3) @(posedge ck_1356meg);

      // ATQA 0x44, 0x00 with correct parity.
      push_byte(8'h44, 1'b1);
      push_byte(8'h00, 1'b1);
      run_frame("atqa");

      // Wrong parity on 0x44.
      push_byte(8'h44, 1'b0);
      run_frame("badpar");

      // Isolated single modulated sample.
      c0 = fa_cycles; bs = bq_mon.size(); fs = fq_mon.size();
      send_sample(1'b1);
      repeat (15) send_sample(1'b0);
      repeat (2) @(posedge ck_1356meg);
      chk("glitch.active", 32'(fa_cycles - c0), 32'd0);
      chk("glitch.nbytes", 32'(bq_mon.size() - bs), 32'd0);
      chk("glitch.nframes", 32'(fq_mon.size() - fs), 32'd0);

      // Five bits then a fully modulated collision bit.
      bits.push_back(1); bits.push_back(0); bits.push_back(1); bits.push_back(1); bits.push_back(0);
      bits.push_back(5);
      run_frame("anticoll");

      // Three bytes against a two-byte limit, then trailing modulation.
      push_byte(8'h11, 1'b1);
      push_byte(8'h22, 1'b1);
      push_byte(8'h33, 1'b1);
      for (int k = 0; k < 5; k++) bits.push_back(1);
      run_frame("overflow");

      // Empty frame: SOF immediately followed by EOF.
      run_frame("empty");

      abort_case("abort_rst", 1'b1);
      push_byte(8'hA5, 1'b1);
      run_frame("after_rst");
      abort_case("abort_en", 1'b0);
      push_byte(8'h3C, 1'b1);
      run_frame("after_en");

      // Randomized frames: byte count, data, parity, tail length and collisions.
      for (int r = 0; r < 10; r++) begin
         nb = $urandom_range(0, 3);
         for (int b = 0; b < nb; b++) begin
            d = 8'($urandom);
            push_byte(d, ($urandom_range(0, 3) != 0) ? ~(^d) : (^d));
         end
         nt = $urandom_range(0, 8);
         for (int b = 0; b < nt; b++) bits.push_back(int'($urandom_range(0, 1)));
         foreach (bits[k]) if ($urandom_range(0, 24) == 0) bits[k] = 2;
         run_frame($sformatf("rand%0d", r));
      end

      chk("both_high", 32'(both_viol), 32'd0);
      chk("active_at_done", 32'(act_viol), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
